qdrc_arbiter: RTL
=================

# qdrc_arbiter

Two-port command arbiter in front of the QDR controller user interface (`usr_rd_strb`/`usr_wr_strb`/`usr_addr`/`usr_wr_data`, `usr_rd_data`/`usr_rd_dvld`). It shares the single-command-per-cycle QDR interface between two requesters with round-robin fairness and holds off all traffic until the PHY reports ready. It tracks every outstanding read in a tag FIFO so that each returned read word is steered to the port that issued it.

## Interface
- `DATA_WIDTH`, 36: QDR word width; user data is `2*DATA_WIDTH`.
- `ADDR_WIDTH`, 21: QDR burst address width.
- `TAG_DEPTH`, 16: outstanding-read capacity; power of two, ≥ controller read latency + 2.

- `clk0`  in  1  controller clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `phy_rdy`  in  1  PHY calibrated; commands are granted only while high.
- `p0_req`, `p1_req`  in  1 each  command valid; held until accepted.
- `p0_we`, `p1_we`  in  1 each  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  ADDR_WIDTH each  command address.
- `p0_wr_data`, `p1_wr_data`  in  2*DATA_WIDTH each  write burst data.
- `p0_rdy`, `p1_rdy`  out  1 each  combinational grant; a transfer occurs when `req & rdy`.
- `p0_rd_data`, `p1_rd_data`  out  2*DATA_WIDTH each  registered copy of `usr_rd_data`, broadcast to both ports.
- `p0_rd_dvld`, `p1_rd_dvld`  out  1 each  read-return strobe for that port.
- `usr_rd_strb`, `usr_wr_strb`  out  1 each  to the controller.
- `usr_addr`  out  ADDR_WIDTH  to the controller.
- `usr_wr_data`  out  2*DATA_WIDTH  to the controller.
- `usr_rd_data`  in  2*DATA_WIDTH  from the controller.
- `usr_rd_dvld`  in  1  from the controller.
- `tag_err`  out  1  sticky: `usr_rd_dvld` arrived while the tag FIFO was empty.

## Operation
- Eligibility: port N is eligible when `pN_req` is high, `phy_rdy` is high, and the port issues a write or the tag FIFO is not full.
- Round-robin:
  - Pointer `rr` resets to 0.
  - If both ports are eligible, port `rr` gets `rdy`.
  - If only one is eligible, it gets `rdy`.
  - After any transfer, `rr` moves to the other port of the one granted.
- At most one `pN_rdy` is high per cycle. `rdy` is never asserted without `req`.
- Issue register, loaded on transfer:
  - `usr_wr_strb <= we`, `usr_rd_strb <= ~we`.
  - `usr_addr` and `usr_wr_data` are loaded from the granted port.
  - With no transfer, both strobes drop to 0. Address and data hold their previous values.
- Tag FIFO: on a read transfer, push the port index (1 bit).
- Read return:
  - On `usr_rd_dvld` with the FIFO non-empty, pop; `pN_rd_dvld` pulses for the popped tag.
  - A push and a pop in the same cycle leave the occupancy unchanged.
- Spurious return: `usr_rd_dvld` with the FIFO empty drops the data, raises no `rd_dvld`, and sets `tag_err` until reset.
- `phy_rdy` falling: no new grants. In-flight reads still drain through the FIFO.
- Reset (asynchronous, also mid-operation) clears:
  - all strobes, `p*_rdy`, `p*_rd_dvld`, `tag_err`, `rr`;
  - FIFO pointers (FIFO empty);
  - `usr_addr`, `usr_wr_data`, `p*_rd_data` to 0.
- Reads in flight across a reset return as spurious and set `tag_err`. This is expected, and software clears it with a reset.

## Timing
- Command latency: a transfer in cycle T puts the strobe on `usr_*` in cycle T+1.
- Read-return latency: `usr_rd_dvld` in cycle R gives `pN_rd_dvld` and `pN_rd_data` in cycle R+1.
- Throughput: one command per cycle sustained; with both ports requesting, they alternate.
- FIFO full: occupancy equal to `TAG_DEPTH` blocks reads only. A pop in the same cycle does not unblock them (full is evaluated from registered occupancy).
- Pointers are `$clog2(TAG_DEPTH)+1` bits, wrapping naturally. Full/empty are decided by the MSB comparison.

## Structure
- Package `qdrc_pkg`: port-index typedef (1 bit), `DEFAULT_TAG_DEPTH = 16`, command struct {we, addr, wr_data}.
- Sub-module `qdrc_tag_fifo`: synchronous 1-bit-wide FIFO with push, pop, full, empty, and dout. Arbiter and issue register stay in `qdrc_arbiter`.

## Test plan
- Reset and PHY gating:
  - Stimulus: hold `phy_rdy`=0 with both `req`=1 for 10 cycles.
  - Response: `p*_rdy`=0, `usr_*_strb`=0. After `phy_rdy`=1, the first grant goes to port 0.
- Alternation:
  - Stimulus: both ports stream writes for 8 cycles.
  - Response: `usr_wr_strb` high on 8 consecutive cycles; addresses alternate p0, p1, p0, …
- Read steering:
  - Stimulus: p0 reads addr 0x10, p1 reads 0x20; model returns 0xA then 0xB, 15 cycles later.
  - Response: `p0_rd_dvld` with 0xA, then `p1_rd_dvld` with 0xB, each one cycle after `usr_rd_dvld`.
- FIFO full:
  - Stimulus: issue 16 p1 reads with no returns; then p1 requests a read and p0 a write.
  - Response: `p1_rdy` stays 0 and p0's write is granted; after one return, `p1_rdy` is granted the following cycle.
- Spurious return:
  - Stimulus: pulse `usr_rd_dvld` with the FIFO empty.
  - Response: no `rd_dvld` on either port; `tag_err`=1 and it persists until `reset_n` is asserted.
- Mid-operation reset:
  - Stimulus: assert `reset_n`=0 with 5 reads outstanding.
  - Response: all outputs are 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/qdrc_pkg.sv
// Shared types and defaults for the two-port QDR command arbiter.
// cmd_t is sized to the default widths; the arbiter's width parameters must match.
package qdrc_pkg;
  localparam int DEFAULT_TAG_DEPTH  = 16;
  localparam int DEFAULT_DATA_WIDTH = 36;
  localparam int DEFAULT_ADDR_WIDTH = 21;

  typedef logic port_idx_t;

  typedef struct packed {
    logic                              we;
    logic [DEFAULT_ADDR_WIDTH-1:0]     addr;
    logic [2*DEFAULT_DATA_WIDTH-1:0]   wr_data;
  } cmd_t;
endpackage

// File: rtl/qdrc_tag_fifo.sv
// 1-bit tag FIFO recording which port issued each outstanding read.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module qdrc_tag_fifo
  import qdrc_pkg::*;
#(
  parameter int DEPTH = DEFAULT_TAG_DEPTH
) (
  input  logic      clk0,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  port_idx_t din,
  output port_idx_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  port_idx_t   mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk0) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/qdrc_arbiter.sv
// Round-robin two-port arbiter in front of the QDR controller user interface,
// with a tag FIFO steering each read return to the port that issued it.
module qdrc_arbiter
  import qdrc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int TAG_DEPTH  = DEFAULT_TAG_DEPTH
) (
  input  logic                    clk0,
  input  logic                    reset_n,
  input  logic                    phy_rdy,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [2*DATA_WIDTH-1:0] p0_wr_data,
  output logic                    p0_rdy,
  output logic [2*DATA_WIDTH-1:0] p0_rd_data,
  output logic                    p0_rd_dvld,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [2*DATA_WIDTH-1:0] p1_wr_data,
  output logic                    p1_rdy,
  output logic [2*DATA_WIDTH-1:0] p1_rd_data,
  output logic                    p1_rd_dvld,
  output logic                    usr_rd_strb,
  output logic                    usr_wr_strb,
  output logic [ADDR_WIDTH-1:0]   usr_addr,
  output logic [2*DATA_WIDTH-1:0] usr_wr_data,
  input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
  input  logic                    usr_rd_dvld,
  output logic                    tag_err
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0] req, elig, grant;
  cmd_t [NUM_PORTS-1:0] cmd;
  cmd_t                 sel;
  port_idx_t            rr, gidx, tag_dout;
  logic                 xfer, push, pop, full, empty;
  logic [2*DATA_WIDTH-1:0] rd_data_q;

  assign req    = {p1_req, p0_req};
  assign cmd[0] = cmd_t'{we: p0_we, addr: p0_addr, wr_data: p0_wr_data};
  assign cmd[1] = cmd_t'{we: p1_we, addr: p1_addr, wr_data: p1_wr_data};

  // Reads need a free tag slot; full comes from registered occupancy only.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_elig
    assign elig[i] = req[i] & phy_rdy & (cmd[i].we | ~full);
  end

  // Grant is gated by reset so rdy reads 0 the moment reset asserts.
  always_comb begin
    grant = '0;
    if (reset_n) begin
      if (&elig) grant[rr] = 1'b1;
      else       grant     = elig;
    end
  end

  assign p0_rdy = grant[0];
  assign p1_rdy = grant[1];
  assign xfer   = |grant;
  assign gidx   = grant[1];
  assign sel    = cmd[gidx];
  assign push   = xfer & ~sel.we;
  assign pop    = usr_rd_dvld & ~empty;

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      rr          <= 1'b0;
      usr_wr_strb <= 1'b0;
      usr_rd_strb <= 1'b0;
      usr_addr    <= '0;
      usr_wr_data <= '0;
    end else begin
      usr_wr_strb <= xfer & sel.we;
      usr_rd_strb <= xfer & ~sel.we;
      if (xfer) begin
        rr          <= ~gidx;
        usr_addr    <= sel.addr;
        usr_wr_data <= sel.wr_data;
      end
    end
  end

  qdrc_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk0    (clk0),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (gidx),
    .dout    (tag_dout),
    .full    (full),
    .empty   (empty)
  );

  // Returns with no outstanding tag are dropped and flagged until reset.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      p0_rd_dvld <= 1'b0;
      p1_rd_dvld <= 1'b0;
      rd_data_q  <= '0;
      tag_err    <= 1'b0;
    end else begin
      p0_rd_dvld <= pop & ~tag_dout;
      p1_rd_dvld <= pop &  tag_dout;
      if (pop) rd_data_q <= usr_rd_data;
      tag_err    <= tag_err | (usr_rd_dvld & empty);
    end
  end

  assign p0_rd_data = rd_data_q;
  assign p1_rd_data = rd_data_q;
endmodule
